// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                            |
// | Description : Command front-end for the 8-bit ALU. Takes one command per  |
// |               valid/ready handshake, pulses BEGIN, streams operand bytes  |
// |               in ALU load order, waits for END, collects one or two       |
// |               result bytes and returns them over a valid/ready handshake. |
// | Ports       : clk, reset (async, active low)                              |
// |               cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y  - command channel   |
// |               alu_begin/alu_op_code/alu_inbus         - to the ALU        |
// |               alu_outbus/alu_end                      - from the ALU      |
// |               res_valid/res_ready/res_hi/res_lo/res_err - result channel  |
// |               busy                                    - not idle          |
// | Options     : ALU_SEQ_TIMEOUT_EN - abort WAIT after TIMEOUT_CYCLES with   |
// |               res_err; without it WAIT holds until alu_end.               |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_x,
  input  logic [7:0]  cmd_y,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_hi,
  output logic [7:0]  res_lo,
  output logic        res_err,
  output logic        busy
);

  // The counter must be able to represent TIMEOUT_CYCLES without wrapping.
  if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("alu_cmd_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_START = 6'b000010,
    S_LOAD  = 6'b000100,
    S_WAIT  = 6'b001000,
    S_CAPT  = 6'b010000,
    S_RESP  = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        err_q, err_d;
  logic [7:0]  load_byte;
  logic        last_byte;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Operand byte presented during LOAD: divide sends the 16-bit dividend
  // high byte first, every other op sends x[7:0] then y.
  always_comb begin
    load_byte = y_q;
    last_byte = 1'b0;
    if (op_q == 2'b11) begin
      case (idx_q)
        2'd0:    load_byte = x_q[15:8];
        2'd1:    load_byte = x_q[7:0];
        default: load_byte = y_q;
      endcase
      last_byte = (idx_q == 2'd2);
    end else begin
      load_byte = (idx_q == 2'd0) ? x_q[7:0] : y_q;
      last_byte = (idx_q == 2'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          x_d   = cmd_x;
          y_d   = cmd_y;
          idx_d = 2'd0;
          hi_d  = 8'h00;
          lo_d  = 8'h00;
          err_d = 1'b0;
          // Divide by zero is answered directly; the ALU is never started.
          if (cmd_op == 2'b11 && cmd_y == 8'h00) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        idx_d   = 2'd0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (last_byte) begin
          state_d = S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (alu_end) begin
          // Two-word results (multiply, divide) deliver the high word first.
          if (op_q[1]) begin
            hi_d    = alu_outbus;
            state_d = S_CAPT;
          end else begin
            hi_d    = 8'h00;
            lo_d    = alu_outbus;
            state_d = S_RESP;
          end
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (cnt_q == c_timeout_last) begin
          hi_d    = 8'h00;
          lo_d    = 8'h00;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_CAPT: begin
        lo_d    = alu_outbus;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      x_q     <= 16'h0000;
      y_q     <= 8'h00;
      idx_q   <= 2'd0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // All outputs decode from registered state only, so none of them has a
  // combinational path from an input.
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_begin   = (state_q == S_START);
  assign alu_op_code = (state_q == S_IDLE) ? 2'b00 : op_q;
  assign alu_inbus   = (state_q == S_LOAD) ? load_byte : 8'h00;
  assign res_valid   = (state_q == S_RESP);
  assign res_hi      = res_valid ? hi_q : 8'h00;
  assign res_lo      = res_valid ? lo_q : 8'h00;
  assign res_err     = res_valid ? err_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_cmd_sequencer                                         |
// | Description : Self-checking bench for alu_cmd_sequencer. A directed reset  |
// |               phase is followed by a precomputed transaction schedule     |
// |               (directed cases then random ones). The ALU is modelled as   |
// |               real arithmetic; expected outputs per cycle come from the   |
// |               transaction timeline.                                       |
// | Options     : ALU_SEQ_TIMEOUT_EN - adds a timeout transaction.            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif
  localparam int NDIR  = 6;
  localparam int NRAND = 40;
  localparam int NREC  = NDIR + NRAND;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_x = 16'h0000;
  logic [7:0]  cmd_y = 8'h00;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus = 8'h00;
  logic        alu_end = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_hi;
  logic [7:0]  res_lo;
  logic        res_err;
  logic        busy;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_end(alu_end),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One transaction: stimulus, ALU behaviour and its timeline (cycle numbers).
  // P: cmd_valid first high, A: accept (IDLE) cycle, W0: first WAIT cycle,
  // E: END cycle, R: first res_valid cycle, X: res_ready cycle, D: back in IDLE.
  typedef struct {
    int op; logic [15:0] x; logic [7:0] y;
    int ed, rd, lead, gap, n;
    int P, A, W0, E, R, X, D;
    bit div0, tmo;
    logic [7:0] w0, w1, eh, el, b0, b1, b2;
    logic ee;
  } rec_t;
  rec_t recs[NREC];

  task automatic set_rec(input int i, input int op, input logic [15:0] x, input logic [7:0] y,
                         input int ed, input int rd, input int lead, input int gap, input bit tmo);
    recs[i].op = op; recs[i].x = x; recs[i].y = y; recs[i].ed = ed; recs[i].rd = rd;
    recs[i].lead = lead; recs[i].gap = gap; recs[i].tmo = tmo;
  endtask

  // Per-cycle comparison against the transaction timeline.
  always @(negedge clk) begin : p_compare
    int c, k, idx;
    logic e_ready, e_busy, e_begin, e_val, e_err;
    logic [1:0] e_op;
    logic [7:0] e_in, e_hi, e_lo;
    if (chk_en) begin
      c = cyc;
      k = -1;
      for (int i = 0; i < NREC; i++)
        if (recs[i].A < c && c < recs[i].D) k = i;
      e_ready = (k < 0); e_busy = (k >= 0); e_begin = 1'b0; e_op = 2'b00;
      e_in = 8'h00; e_val = 1'b0; e_hi = 8'h00; e_lo = 8'h00; e_err = 1'b0;
      if (k >= 0) begin
        e_op = 2'(recs[k].op);
        if (!recs[k].div0) begin
          e_begin = (c == recs[k].A + 1);
          idx = c - recs[k].A - 2;
          if (idx >= 0 && idx < recs[k].n)
            e_in = (idx == 0) ? recs[k].b0 : (idx == 1) ? recs[k].b1 : recs[k].b2;
        end
        if (c >= recs[k].R) begin
          e_val = 1'b1; e_hi = recs[k].eh; e_lo = recs[k].el; e_err = recs[k].ee;
        end
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("alu_begin", 32'(alu_begin), 32'(e_begin));
      chk("alu_op_code", 32'(alu_op_code), 32'(e_op));
      chk("alu_inbus", 32'(alu_inbus), 32'(e_in));
      chk("res_valid", 32'(res_valid), 32'(e_val));
      chk("res_hi", 32'(res_hi), 32'(e_hi));
      chk("res_lo", 32'(res_lo), 32'(e_lo));
      chk("res_err", 32'(res_err), 32'(e_err));
      // Hand-computed anchors for the directed transactions.
      if (k == 0 && c == recs[0].R) chk("pin_add", 32'({res_err, res_hi, res_lo}), 32'h0_0038);
      if (k == 1 && c == recs[1].R) chk("pin_mul", 32'({res_err, res_hi, res_lo}), 32'h0_0084);
      if (k == 2 && c == recs[2].A + 2) chk("pin_div_in0", 32'(alu_inbus), 32'h00);
      if (k == 2 && c == recs[2].A + 3) chk("pin_div_in1", 32'(alu_inbus), 32'h64);
      if (k == 2 && c == recs[2].A + 4) chk("pin_div_in2", 32'(alu_inbus), 32'h07);
      if (k == 2 && c == recs[2].R) chk("pin_div", 32'({res_err, res_hi, res_lo}), 32'h0_020E);
      if (k == 3 && c == recs[3].A + 1) chk("pin_dz_nobegin", 32'(alu_begin), 32'h0);
      if (k == 3 && c == recs[3].R) chk("pin_dz", 32'({res_err, res_hi, res_lo}), 32'h1_0000);
      if (k == 4 && c == recs[4].A + 4) chk("pin_lat_before", 32'(res_valid), 32'h0);
      if (k == 4 && c == recs[4].A + 5) chk("pin_lat_at5", 32'(res_valid), 32'h1);
`ifdef ALU_SEQ_TIMEOUT_EN
      if (k == 5 && c == recs[5].A + 4 + 15) chk("pin_tmo_before", 32'(res_valid), 32'h0);
      if (k == 5 && c == recs[5].A + 4 + 16) chk("pin_tmo_err", 32'({res_valid, res_err}), 32'h3);
      if (k == 5 && c == recs[5].A + 4 + 26) chk("pin_tmo_hold", 32'({res_valid, res_err}), 32'h3);
`endif
    end
  end

  initial begin : p_main
    int t0, idle_prev, prev_a, last_d;
    logic [15:0] prod, quo;
    logic [7:0] xl;

    // ---- Reset held, then reset asserted in the middle of a multiply load.
    repeat (3) @(negedge clk);
    chk("reset_hold", 32'({cmd_ready, alu_begin, alu_op_code, alu_inbus, res_valid,
                           res_hi, res_lo, res_err, busy}), 32'h4000_0000);
    reset = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_x = 16'h000C; cmd_y = 8'h0B;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_begin", 32'(alu_begin), 32'h1);
    @(negedge clk);
    chk("mid_load_byte", 32'({alu_op_code, alu_inbus}), 32'h20C);
    #2 reset = 1'b0;
    #1 chk("reset_midload", 32'({cmd_ready, alu_begin, alu_op_code, alu_inbus, res_valid,
                                 res_hi, res_lo, res_err, busy}), 32'h4000_0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 32'({res_valid, busy, cmd_ready}), 32'h1);
    end

    // ---- Build the transaction schedule.
    set_rec(0, 0, 16'h0025, 8'h13, 3, 0, 0, 1, 1'b0);
    set_rec(1, 2, 16'h000C, 8'h0B, 2, 1, 0, 1, 1'b0);
    set_rec(2, 3, 16'h0064, 8'h07, 1, 0, 0, 1, 1'b0);
    set_rec(3, 3, 16'h1234, 8'h00, 0, 2, 0, 1, 1'b0);
    set_rec(4, 0, 16'h00F0, 8'h20, 0, 0, 2, 0, 1'b0);
`ifdef ALU_SEQ_TIMEOUT_EN
    set_rec(5, 2, 16'h0003, 8'h05, 0, 10, 0, 1, 1'b1);
`else
    set_rec(5, 2, 16'h0003, 8'h05, 0, 10, 0, 1, 1'b0);
`endif
    for (int i = NDIR; i < NREC; i++) begin
      set_rec(i, int'($urandom_range(0, 3)), 16'($urandom),
              ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
`ifdef ALU_SEQ_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0 && !(recs[i].op == 3 && recs[i].y == 8'h00)) recs[i].tmo = 1'b1;
`endif
    end

    t0 = cyc + 1;
    idle_prev = t0;
    prev_a = t0 - 1;
    for (int i = 0; i < NREC; i++) begin
      recs[i].P = idle_prev + recs[i].gap - recs[i].lead;
      if (recs[i].P < prev_a + 1) recs[i].P = prev_a + 1;
      recs[i].A = (recs[i].P > idle_prev) ? recs[i].P : idle_prev;
      recs[i].div0 = (recs[i].op == 3 && recs[i].y == 8'h00);
      recs[i].n = (recs[i].op == 3) ? 3 : 2;
      xl = recs[i].x[7:0];
      if (recs[i].op == 3) begin
        recs[i].b0 = recs[i].x[15:8]; recs[i].b1 = xl; recs[i].b2 = recs[i].y;
      end else begin
        recs[i].b0 = xl; recs[i].b1 = recs[i].y; recs[i].b2 = 8'h00;
      end
      // ALU behaviour: true arithmetic; two-word results come high word first.
      recs[i].w1 = 8'($urandom);
      recs[i].eh = 8'h00; recs[i].el = 8'h00; recs[i].ee = 1'b0;
      case (recs[i].op)
        0: begin recs[i].el = xl + recs[i].y; recs[i].w0 = recs[i].el; end
        1: begin recs[i].el = xl - recs[i].y; recs[i].w0 = recs[i].el; end
        2: begin
          prod = 16'(xl) * 16'(recs[i].y);
          recs[i].eh = prod[15:8]; recs[i].el = prod[7:0];
          recs[i].w0 = recs[i].eh; recs[i].w1 = recs[i].el;
        end
        default: begin
          if (!recs[i].div0) begin
            quo = recs[i].x / 16'(recs[i].y);
            prod = recs[i].x % 16'(recs[i].y);
            recs[i].eh = prod[7:0]; recs[i].el = quo[7:0];
          end
          recs[i].w0 = recs[i].eh; recs[i].w1 = recs[i].el;
        end
      endcase
      if (recs[i].div0 || recs[i].tmo) begin
        recs[i].eh = 8'h00; recs[i].el = 8'h00; recs[i].ee = 1'b1;
      end
      recs[i].W0 = recs[i].A + 2 + recs[i].n;
      recs[i].E = -100;
      if (recs[i].div0) recs[i].R = recs[i].A + 1;
      else if (recs[i].tmo) recs[i].R = recs[i].W0 + TMO;
      else begin
        recs[i].E = recs[i].W0 + recs[i].ed;
        recs[i].R = recs[i].E + 1 + ((recs[i].op >= 2) ? 1 : 0);
      end
      recs[i].X = recs[i].R + recs[i].rd;
      recs[i].D = recs[i].X + 1;
      prev_a = recs[i].A;
      idle_prev = recs[i].D;
    end
    last_d = idle_prev;

    // ---- Drive the schedule one cycle at a time; junk on unused inputs.
    chk_en = 1'b1;
    for (int c = t0; c <= last_d + 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_x = 16'($urandom); cmd_y = 8'($urandom);
      res_ready = 1'($urandom); alu_end = 1'($urandom); alu_outbus = 8'($urandom);
      for (int i = 0; i < NREC; i++) begin
        if (recs[i].P <= c && c <= recs[i].A) begin
          cmd_valid = 1'b1; cmd_op = 2'(recs[i].op); cmd_x = recs[i].x; cmd_y = recs[i].y;
        end
        if (recs[i].R <= c && c <= recs[i].X) res_ready = (c == recs[i].X);
        if (recs[i].div0) begin
          if (recs[i].A < c && c < recs[i].D) alu_end = 1'b0;
        end else begin
          if (recs[i].W0 <= c && c < recs[i].D) alu_end = (c == recs[i].E);
          if (c == recs[i].E) alu_outbus = recs[i].w0;
          if (c == recs[i].E + 1) alu_outbus = recs[i].w1;
        end
      end
    end
    @(posedge clk);
    chk_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
